// File: rtl/conv1d_stream_pkg.sv
// ============================================================================
// Module : conv1d_pkg
// Brief  : Shared state encoding and fixed-point sizing helpers for conv1d_stream.
// Rev    : 1.0  initial streaming release
// ============================================================================
`default_nettype none

package conv1d_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_MAC    = 3'd1,
        S_BIAS   = 3'd2,
        S_CLIP   = 3'd3,
        S_NARROW = 3'd4,
        S_RELU   = 3'd5,
        S_OUTPUT = 3'd6
    } conv1d_state_t;

    // Products are 2W wide; log2(taps) guard bits keep the whole sum exact.
    function automatic int acc_width(input int w, input int k, input int in_d);
        return 2 * w + $clog2(k * in_d);
    endfunction

    // Bounds are returned sign-wrapped to aw bits so callers can truncate freely.
    function automatic longint clip_lo(input int w, input int frac, input int aw);
        longint v;
        v = -((longint'(1) <<< (w - 1)) <<< frac);
        if (aw < 64) v = (v <<< (64 - aw)) >>> (64 - aw);
        return v;
    endfunction

    function automatic longint clip_hi(input int w, input int frac, input int aw);
        longint v;
        v = ((longint'(1) <<< (w - 1)) - 1) <<< frac;
        if (aw < 64) v = (v <<< (64 - aw)) >>> (64 - aw);
        return v;
    endfunction

endpackage

`default_nettype wire

// File: rtl/conv1d_stream_if.sv
// ============================================================================
// Module : conv1d_stream_if
// Brief  : Tap-input and result-output valid/ready bundle of conv1d_stream.
// Rev    : 1.0  initial streaming release
// ============================================================================
`default_nettype none

interface conv1d_stream_if #(
    parameter int W     = 16,
    parameter int IN_D  = 4,
    parameter int OUT_D = 4,
    parameter int K     = 4
);
    logic                  in_v;
    logic                  in_ready;
    logic                  apply_relu;
    logic [K*IN_D*W-1:0]   packed_taps;
    logic                  out_v;
    logic                  out_ready;
    logic [OUT_D*W-1:0]    packed_out;

    modport master (
        output in_v, apply_relu, packed_taps, out_ready,
        input  in_ready, out_v, packed_out
    );

    modport slave (
        input  in_v, apply_relu, packed_taps, out_ready,
        output in_ready, out_v, packed_out
    );
endinterface

`default_nettype wire

// File: rtl/conv1d_stream_weight_rom.sv
// ============================================================================
// Module : conv1d_weight_rom
// Brief  : Weight/bias store; weights packed in k,i,o order (first entry in the
//          MSBs, same order as weights.hex), biases 2W wide with 2*FRAC frac bits.
// Rev    : 1.0  initial streaming release
// ============================================================================
`default_nettype none

module conv1d_weight_rom #(
    parameter int                       W            = 16,
    parameter int                       IN_D         = 4,
    parameter int                       OUT_D        = 4,
    parameter int                       K            = 4,
    parameter int                       IDXW         = 4,
    parameter logic [K*IN_D*OUT_D*W-1:0] WEIGHTS_INIT = '0,
    parameter logic [OUT_D*2*W-1:0]     BIAS_INIT    = '0
) (
    input  wire logic [IDXW-1:0]        i_idx,
    output logic      [OUT_D*W-1:0]     o_w_row,
    output logic      [OUT_D*2*W-1:0]   o_bias
);

    localparam int C_NTAP = K * IN_D;
    localparam int C_ROWW = OUT_D * W;

    always_comb begin
        o_w_row = '0;
        for (int r = 0; r < C_NTAP; r++) begin
            if (i_idx == IDXW'(r)) o_w_row = WEIGHTS_INIT[(C_NTAP - r)*C_ROWW-1 -: C_ROWW];
        end
    end

    assign o_bias = BIAS_INIT;

endmodule

`default_nettype wire

// File: rtl/conv1d_stream.sv
// ============================================================================
// Module : conv1d_stream
// Brief  : Dilated causal 1-D conv layer, one time-multiplexed MAC row of OUT_D
//          lanes; optional round-half-up enabled by defining CONV1D_ROUND_EN.
// Rev    : 1.0  initial streaming release
// ============================================================================
`default_nettype none

module conv1d_stream
    import conv1d_pkg::*;
#(
    parameter int                        W            = 16,
    parameter int                        FRAC         = 12,
    parameter int                        IN_D         = 4,
    parameter int                        OUT_D        = 4,
    parameter int                        K            = 4,
    parameter logic [K*IN_D*OUT_D*W-1:0] WEIGHTS_INIT = '0,
    parameter logic [OUT_D*2*W-1:0]      BIAS_INIT    = '0
) (
    input  wire logic       clk,
    input  wire logic       rst,
    conv1d_stream_if.slave  bus
);

    localparam int C_NTAP = K * IN_D;
    localparam int C_IDXW = (C_NTAP > 1) ? $clog2(C_NTAP) : 1;
    localparam int C_AW   = acc_width(W, K, IN_D);
    localparam logic signed [C_AW-1:0] C_LO = C_AW'(clip_lo(W, FRAC, C_AW));
    localparam logic signed [C_AW-1:0] C_HI = C_AW'(clip_hi(W, FRAC, C_AW));
`ifdef CONV1D_ROUND_EN
    localparam logic signed [C_AW-1:0] C_RND = C_AW'(longint'(1) <<< (FRAC - 1));
`else
    localparam logic signed [C_AW-1:0] C_RND = '0;
`endif

    conv1d_state_t r_state, w_next;
    logic                     w_in_ready;
    logic                     w_out_v;

    logic signed [W-1:0]      r_tap [C_NTAP];
    logic                     r_relu;
    logic [C_IDXW-1:0]        r_idx;
    logic signed [C_AW-1:0]   r_acc [OUT_D];
    logic [W-1:0]             r_res [OUT_D];
    logic [OUT_D*W-1:0]       r_out;

    logic [OUT_D*W-1:0]       w_row;
    logic [OUT_D*2*W-1:0]     w_bias_vec;
    logic signed [W-1:0]      w_tap;
    logic signed [W-1:0]      w_wt   [OUT_D];
    logic signed [2*W-1:0]    w_bias [OUT_D];
    logic signed [2*W-1:0]    w_prod [OUT_D];
    logic                     w_last;

    conv1d_weight_rom #(
        .W            (W),
        .IN_D         (IN_D),
        .OUT_D        (OUT_D),
        .K            (K),
        .IDXW         (C_IDXW),
        .WEIGHTS_INIT (WEIGHTS_INIT),
        .BIAS_INIT    (BIAS_INIT)
    ) u_rom (
        .i_idx   (r_idx),
        .o_w_row (w_row),
        .o_bias  (w_bias_vec)
    );

    assign w_tap  = r_tap[r_idx];
    assign w_last = (r_idx == C_IDXW'(C_NTAP - 1));

    always_comb begin
        for (int o = 0; o < OUT_D; o++) begin
            w_wt[o]   = w_row[(OUT_D - o)*W-1 -: W];
            w_bias[o] = w_bias_vec[(OUT_D - o)*2*W-1 -: 2*W];
            w_prod[o] = (2*W)'(w_tap) * (2*W)'(w_wt[o]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next     = r_state;
        w_in_ready = 1'b0;
        w_out_v    = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_v) w_next = S_MAC;
            end
            S_MAC:    if (w_last) w_next = S_BIAS;
            S_BIAS:   w_next = S_CLIP;
            S_CLIP:   w_next = S_NARROW;
            S_NARROW: w_next = S_RELU;
            S_RELU:   w_next = S_OUTPUT;
            S_OUTPUT: begin
                w_out_v = 1'b1;
                if (bus.out_ready) w_next = S_IDLE;
            end
            default:  w_next = S_IDLE;
        endcase
    end

    // Datapath; r_out only changes on entry to OUTPUT so it holds through IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_relu <= 1'b0;
            r_idx  <= '0;
            r_out  <= '0;
            for (int j = 0; j < C_NTAP; j++) r_tap[j] <= '0;
            for (int o = 0; o < OUT_D; o++) begin
                r_acc[o] <= '0;
                r_res[o] <= '0;
            end
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.in_v) begin
                        for (int j = 0; j < C_NTAP; j++)
                            r_tap[j] <= bus.packed_taps[(C_NTAP - j)*W-1 -: W];
                        r_relu <= bus.apply_relu;
                        r_idx  <= '0;
                        for (int o = 0; o < OUT_D; o++) r_acc[o] <= '0;
                    end
                end
                S_MAC: begin
                    for (int o = 0; o < OUT_D; o++)
                        r_acc[o] <= r_acc[o] + C_AW'(w_prod[o]);
                    r_idx <= w_last ? '0 : r_idx + C_IDXW'(1);
                end
                S_BIAS: begin
                    for (int o = 0; o < OUT_D; o++)
                        r_acc[o] <= r_acc[o] + C_AW'(w_bias[o]) + C_RND;
                end
                S_CLIP: begin
                    for (int o = 0; o < OUT_D; o++) begin
                        if (r_acc[o] < C_LO)      r_acc[o] <= C_LO;
                        else if (r_acc[o] > C_HI) r_acc[o] <= C_HI;
                    end
                end
                S_NARROW: begin
                    for (int o = 0; o < OUT_D; o++)
                        r_res[o] <= r_acc[o][W+FRAC-1:FRAC];
                end
                S_RELU: begin
                    for (int o = 0; o < OUT_D; o++)
                        r_out[(OUT_D - o)*W-1 -: W] <= (r_relu && r_res[o][W-1]) ? '0 : r_res[o];
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.out_v      = w_out_v;
    assign bus.packed_out = r_out;

endmodule

`default_nettype wire

// File: tb/tb_conv1d_stream.sv
// ============================================================================
// Module : tb_conv1d_stream
// Brief  : Three conv1d_stream instances with different weight/bias sets run in
//          lockstep from shared stimulus; results checked against a scoreboard.
// Rev    : 1.0  initial streaming release
// ============================================================================
`default_nettype none

module tb_conv1d_stream;

    localparam int W = 16, FRAC = 12, IN_D = 2, OUT_D = 2, K = 4;
    localparam int NTAP = K * IN_D;
    localparam int PW   = NTAP * W;
    localparam int OW   = OUT_D * W;

    localparam logic [NTAP*OUT_D*W-1:0] WA  = {(NTAP*OUT_D){16'h1000}};
    localparam logic [NTAP*OUT_D*W-1:0] WC  = {{OUT_D{16'h0800}}, {((NTAP-1)*OUT_D){16'h0000}}};
    localparam logic [OUT_D*2*W-1:0]    B0  = '0;
    localparam logic [OUT_D*2*W-1:0]    BM1 = {OUT_D{32'hFF00_0000}};
`ifdef CONV1D_ROUND_EN
    localparam longint RND = 2048;
    localparam logic [OW-1:0] EXP_SINGLE = 32'h0001_0001;
`else
    localparam longint RND = 0;
    localparam logic [OW-1:0] EXP_SINGLE = 32'h0000_0000;
`endif

    logic clk = 1'b0;
    logic rst;
    logic r_in_v, r_relu, r_out_ready;
    logic [PW-1:0] r_taps;

    always #5 clk = ~clk;

    conv1d_stream_if #(.W(W), .IN_D(IN_D), .OUT_D(OUT_D), .K(K)) if_a ();
    conv1d_stream_if #(.W(W), .IN_D(IN_D), .OUT_D(OUT_D), .K(K)) if_b ();
    conv1d_stream_if #(.W(W), .IN_D(IN_D), .OUT_D(OUT_D), .K(K)) if_c ();

    assign if_a.in_v = r_in_v;  assign if_a.apply_relu = r_relu;
    assign if_a.packed_taps = r_taps;  assign if_a.out_ready = r_out_ready;
    assign if_b.in_v = r_in_v;  assign if_b.apply_relu = r_relu;
    assign if_b.packed_taps = r_taps;  assign if_b.out_ready = r_out_ready;
    assign if_c.in_v = r_in_v;  assign if_c.apply_relu = r_relu;
    assign if_c.packed_taps = r_taps;  assign if_c.out_ready = r_out_ready;

    conv1d_stream #(.W(W), .FRAC(FRAC), .IN_D(IN_D), .OUT_D(OUT_D), .K(K),
                    .WEIGHTS_INIT(WA), .BIAS_INIT(B0))
        dut_a (.clk(clk), .rst(rst), .bus(if_a));
    conv1d_stream #(.W(W), .FRAC(FRAC), .IN_D(IN_D), .OUT_D(OUT_D), .K(K),
                    .WEIGHTS_INIT(WA), .BIAS_INIT(BM1))
        dut_b (.clk(clk), .rst(rst), .bus(if_b));
    conv1d_stream #(.W(W), .FRAC(FRAC), .IN_D(IN_D), .OUT_D(OUT_D), .K(K),
                    .WEIGHTS_INIT(WC), .BIAS_INIT(B0))
        dut_c (.clk(clk), .rst(rst), .bus(if_c));

    typedef struct packed {
        logic [OW-1:0] a;
        logic [OW-1:0] b;
        logic [OW-1:0] c;
    } exp_t;

    exp_t          sb_q[$];
    exp_t          mon_e;
    logic [OW-1:0] last_a, last_b, last_c;
    int            n_checks = 0;
    int            n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Integer reference: sel 0 = unit weights/zero bias, 1 = unit weights/-1.0 bias,
    // 2 = 0.5 weight on tap 0 channel 0 only.
    function automatic logic [OW-1:0] model(input int sel, input logic [PW-1:0] taps, input logic relu);
        logic [OW-1:0] r;
        logic [W-1:0]  n;
        longint acc, t, wv, lo, hi;
        lo = -(longint'(32768) * 4096);
        hi = longint'(32767) * 4096;
        r  = '0;
        for (int o = 0; o < OUT_D; o++) begin
            acc = (sel == 1) ? -(longint'(1) <<< 24) : 0;
            for (int k = 0; k < K; k++) begin
                for (int i = 0; i < IN_D; i++) begin
                    t = longint'($signed(taps[(NTAP - (k*IN_D + i))*W-1 -: W]));
                    if (sel == 2) wv = (k == 0 && i == 0) ? 2048 : 0;
                    else          wv = 4096;
                    acc += t * wv;
                end
            end
            acc += RND;
            if (acc < lo) acc = lo;
            if (acc > hi) acc = hi;
            acc = acc >>> FRAC;
            n = acc[W-1:0];
            if (relu && n[W-1]) n = '0;
            r[(OUT_D - o)*W-1 -: W] = n;
        end
        return r;
    endfunction

    always @(negedge clk) begin
        if (!rst && if_a.out_v && r_out_ready) begin
            if (sb_q.size() == 0) begin
                check_eq("sb_unexpected", 64'(sb_q.size()), 64'd1);
            end else begin
                mon_e = sb_q.pop_front();
                check_eq("out_a", 64'(if_a.packed_out), 64'(mon_e.a));
                check_eq("out_b", 64'(if_b.packed_out), 64'(mon_e.b));
                check_eq("out_c", 64'(if_c.packed_out), 64'(mon_e.c));
                check_eq("lockstep_v", 64'({if_b.out_v, if_c.out_v}), 64'd3);
                last_a = if_a.packed_out;
                last_b = if_b.packed_out;
                last_c = if_c.packed_out;
            end
        end
    end

    // Entered and left at posedge+#1.
    task automatic send(input logic [PW-1:0] taps, input logic relu);
        logic done;
        exp_t e;
        done   = 1'b0;
        r_taps = taps;
        r_relu = relu;
        r_in_v = 1'b1;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (if_a.in_ready) begin
                e.a = model(0, taps, relu);
                e.b = model(1, taps, relu);
                e.c = model(2, taps, relu);
                sb_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
        end
        r_in_v = 1'b0;
        check_eq("accept", 64'(done), 64'd1);
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            @(posedge clk); #1;
            n++;
        end while (sb_q.size() != 0 && n < budget);
        check_eq("drain", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, checks=%0d", n_checks);
        $fatal(1);
    end

    initial begin
        int edges;
        logic seen;
        logic [OW-1:0] held;

        rst = 1'b1; r_in_v = 1'b0; r_relu = 1'b0; r_out_ready = 1'b0; r_taps = '0;
        last_a = '0; last_b = '0; last_c = '0;
        @(negedge clk);
        check_eq("rst_in_ready", 64'(if_a.in_ready), 64'd1);
        check_eq("rst_out_v",    64'(if_a.out_v),    64'd0);
        check_eq("rst_out",      64'(if_a.packed_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        r_out_ready = 1'b1;

        // 0.5 taps through unit weights, with latency measurement
        send({NTAP{16'h0800}}, 1'b0);
        edges = 0; seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (if_a.out_v) seen = 1'b1;
            else            edges++;
        end
        check_eq("latency", 64'(edges), 64'd12);
        drain(40);
        check_eq("half_taps", 64'(last_a), 64'h4000_4000);

        send({NTAP{16'h4000}}, 1'b0);
        drain(40);
        check_eq("clip_hi", 64'(last_a), 64'h7FFF_7FFF);

        send({NTAP{16'hC000}}, 1'b0);
        drain(40);
        check_eq("clip_lo", 64'(last_a), 64'h8000_8000);

        send('0, 1'b0);
        drain(40);
        check_eq("bias_norelu", 64'(last_b), 64'hF000_F000);
        send('0, 1'b1);
        drain(40);
        check_eq("bias_relu", 64'(last_b), 64'h0000_0000);

        send({16'h0001, {(NTAP-1){16'h0000}}}, 1'b0);
        drain(40);
        check_eq("single_tap", 64'(last_c), 64'(EXP_SINGLE));

        // output back-pressure: result must hold and new taps must be refused
        r_out_ready = 1'b0;
        send({NTAP{16'h0123}}, 1'b0);
        seen = 1'b0;
        for (int n = 0; n < 40 && !seen; n++) begin
            @(negedge clk);
            if (if_a.out_v) seen = 1'b1;
        end
        check_eq("stall_outv_seen", 64'(seen), 64'd1);
        held = if_a.packed_out;
        for (int n = 0; n < 5; n++) begin
            @(posedge clk); #1;
            r_in_v = 1'b1;
            r_taps = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            check_eq("stall_out_v",    64'(if_a.out_v),      64'd1);
            check_eq("stall_hold",     64'(if_a.packed_out), 64'(held));
            check_eq("stall_in_ready", 64'(if_a.in_ready),   64'd0);
        end
        @(posedge clk); #1;
        r_in_v = 1'b0;
        r_out_ready = 1'b1;
        drain(10);
        send({NTAP{16'hFE00}}, 1'b1);
        drain(40);

        // reset in the middle of MAC must abort without a partial result
        send({NTAP{16'h0400}}, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        sb_q.delete();
        #1;
        check_eq("abort_out_v",    64'(if_a.out_v),      64'd0);
        check_eq("abort_in_ready", 64'(if_a.in_ready),   64'd1);
        check_eq("abort_out",      64'(if_a.packed_out), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        send({NTAP{16'h0200}}, 1'b0);
        drain(40);
        check_eq("post_abort", 64'(last_a), 64'h1000_1000);

        // back-to-back random samples
        for (int n = 0; n < 6; n++)
            send({$urandom, $urandom, $urandom, $urandom}, 1'($urandom_range(1, 0)));
        drain(200);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
